os_scheduler: RTL and testbench

OS_SCHEDULER -- requirements
Module: os_scheduler

---
 rtl/ozdefs.sv | 35 +++
 rtl/os_scheduler.sv | 156 +++++++++++++++
 tb/tb_os_scheduler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ozdefs.sv
// Shared link-training definitions: LTSSM state encoding and PCIe 8b/10b
// ordered-set symbol values used by the transmit-side schedulers.
package ozdefs;

  typedef enum logic [4:0] {
    DETECT_QUIET             = 5'd0,
    DETECT_ACTIVE            = 5'd1,
    POLLING_ACTIVE           = 5'd2,
    POLLING_ACTIVE_START_TS1 = 5'd3,
    POLLING_CONFIG           = 5'd4,
    POLLING_COMPLIANCE       = 5'd5,
    CONFIG_LINKWIDTH_START   = 5'd6,
    CONFIG_LINKWIDTH_ACCEPT  = 5'd7,
    CONFIG_LANENUM_WAIT      = 5'd8,
    CONFIG_LANENUM_ACCEPT    = 5'd9,
    CONFIG_COMPLETE          = 5'd10,
    CONFIG_IDLE              = 5'd11,
    L0                       = 5'd12,
    RECOVERY_RCVRLOCK        = 5'd13,
    RECOVERY_RCVRCFG         = 5'd14,
    RECOVERY_IDLE            = 5'd15,
    L0S                      = 5'd16,
    L1                       = 5'd17,
    L2                       = 5'd18,
    DISABLED                 = 5'd19,
    LOOPBACK                 = 5'd20,
    HOT_RESET                = 5'd21
  } LTSSM_State;

  localparam logic [7:0] SYM_COM   = 8'hBC;  // K28.5
  localparam logic [7:0] SYM_SKP   = 8'h1C;  // K28.0
  localparam logic [7:0] SYM_TS1ID = 8'h4A;  // D10.2
  localparam logic [7:0] SYM_TS2ID = 8'h45;  // D5.2

endpackage

// File: rtl/os_scheduler.sv
// Ordered-set scheduler: emits TS1/TS2/SKP ordered sets one symbol per clock,
// choosing the next set only at set boundaries and inserting periodic SKPs.
module os_scheduler
  import ozdefs::*;
#(
  parameter int SKP_INTERVAL = 8
) (
  input  logic        clk,
  input  logic        p2md_rstn,
  input  logic        en_n,
  input  LTSSM_State  currLtssmState,
  input  logic [39:0] ts1Bytes1Thru5,
  input  logic [39:0] ts2Bytes1Thru5,
  output logic [7:0]  rxdata,
  output logic        rxdatak,
  output logic        rxvalid,
  output logic        os_start,
  output logic        os_done,
  output logic [15:0] ts_count
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND_TS  = 2'd1;
  localparam logic [1:0] SEND_SKP = 2'd2;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_SKP  = 2'd1;
  localparam logic [1:0] SEL_TS1  = 2'd2;
  localparam logic [1:0] SEL_TS2  = 2'd3;

  localparam logic [3:0] TS_LAST  = 4'd15;
  localparam logic [3:0] SKP_LAST = 4'd3;
  localparam logic [7:0] SKP_LIMIT = 8'(SKP_INTERVAL);

  logic [1:0]  state;
  logic [3:0]  ptr;
  logic [39:0] snap;
  logic        is_ts2;
  logic [1:0]  prev_sel;
  logic [7:0]  skp_cnt;

  logic [1:0]  sel;
  logic        last_sym;
  logic        decide;
  logic        go;
  logic        changed;
  logic        ts_done;
  logic [7:0]  skp_inc;
  logic        insert_skp;

  always_comb begin
    sel = SEL_NONE;
    case (currLtssmState)
      POLLING_ACTIVE:           sel = SEL_SKP;
      POLLING_ACTIVE_START_TS1,
      CONFIG_LINKWIDTH_START,
      CONFIG_LINKWIDTH_ACCEPT,
      CONFIG_LANENUM_ACCEPT,
      CONFIG_COMPLETE,
      CONFIG_IDLE,
      L0:                       sel = SEL_TS1;
      POLLING_CONFIG:           sel = SEL_TS2;
      default:                  sel = SEL_NONE;
    endcase
  end

  // A decision point is any IDLE cycle or the cycle showing the final symbol,
  // so the choice made here lands on the very next cycle with no gap.
  assign ts_done    = (state == SEND_TS) && (ptr == TS_LAST);
  assign last_sym   = ts_done || ((state == SEND_SKP) && (ptr == SKP_LAST));
  assign decide     = (state == IDLE) || last_sym;
  assign go         = !en_n && (sel != SEL_NONE);
  assign changed    = (sel != prev_sel);
  assign skp_inc    = skp_cnt + 8'd1;
  assign insert_skp = ts_done && !changed && (skp_inc >= SKP_LIMIT);

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge p2md_rstn) begin
    if (!p2md_rstn) begin
      state    <= IDLE;
      ptr      <= 4'd0;
      snap     <= 40'd0;
      is_ts2   <= 1'b0;
      prev_sel <= SEL_NONE;
      skp_cnt  <= 8'd0;
      ts_count <= 16'd0;
    end else if (decide) begin
      prev_sel <= sel;
      ptr      <= 4'd0;

      if (changed) begin
        ts_count <= 16'd0;
        skp_cnt  <= 8'd0;
      end else if (ts_done) begin
        if (ts_count != 16'hFFFF) ts_count <= ts_count + 16'd1;
        skp_cnt <= insert_skp ? 8'd0 : skp_inc;
      end else if (state == SEND_SKP) begin
        skp_cnt <= 8'd0;
      end

      if (!go) begin
        state <= IDLE;
      end else if ((sel == SEL_SKP) || insert_skp) begin
        state <= SEND_SKP;
      end else begin
        // Symbols 1..5 are frozen here so mid-set input changes cannot tear the set.
        state  <= SEND_TS;
        is_ts2 <= (sel == SEL_TS2);
        snap   <= (sel == SEL_TS2) ? ts2Bytes1Thru5 : ts1Bytes1Thru5;
      end
    end else if (state != IDLE) begin
      ptr <= ptr + 4'd1;
    end
  end

  always_comb begin
    rxdata   = 8'h00;
    rxdatak  = 1'b0;
    rxvalid  = 1'b0;
    os_start = 1'b0;
    os_done  = 1'b0;
    case (state)
      SEND_TS: begin
        rxvalid  = 1'b1;
        os_start = (ptr == 4'd0);
        os_done  = (ptr == TS_LAST);
        case (ptr)
          4'd0: begin
            rxdata  = SYM_COM;
            rxdatak = 1'b1;
          end
          4'd1:    rxdata = snap[7:0];
          4'd2:    rxdata = snap[15:8];
          4'd3:    rxdata = snap[23:16];
          4'd4:    rxdata = snap[31:24];
          4'd5:    rxdata = snap[39:32];
          default: rxdata = is_ts2 ? SYM_TS2ID : SYM_TS1ID;
        endcase
      end
      SEND_SKP: begin
        rxvalid  = 1'b1;
        rxdatak  = 1'b1;
        os_start = (ptr == 4'd0);
        os_done  = (ptr == SKP_LAST);
        rxdata   = (ptr == 4'd0) ? SYM_COM : SYM_SKP;
      end
      default: begin
        rxdata  = 8'h00;
        rxdatak = 1'b0;
        rxvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_os_scheduler.sv
// Directed bench for os_scheduler: one instance at the default SKP interval,
// one at interval 2, each driven through hand-computed ordered-set sequences.
module tb_os_scheduler;
  import ozdefs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a;
  LTSSM_State  state_a;
  logic [39:0] ts1_a, ts2_a;
  logic [7:0]  data_a;
  logic        k_a, valid_a, start_a, done_a;
  logic [15:0] cnt_a;

  logic        rst_b, en_b;
  LTSSM_State  state_b;
  logic [39:0] ts1_b, ts2_b;
  logic [7:0]  data_b;
  logic        k_b, valid_b, start_b, done_b;
  logic [15:0] cnt_b;

  logic [11:0] obs_a, obs_b;
  assign obs_a = {valid_a, k_a, start_a, done_a, data_a};
  assign obs_b = {valid_b, k_b, start_b, done_b, data_b};

  localparam logic [39:0] TS1_A   = 40'h05_04_03_02_01;
  localparam logic [39:0] TS1_ALT = 40'hEE_DD_CC_BB_AA;
  localparam logic [39:0] TS1_B   = 40'h55_44_33_22_11;
  localparam logic [39:0] TS2_B   = 40'h0E_0D_0C_0B_0A;
  localparam logic [7:0]  TS1ID   = 8'h4A;
  localparam logic [7:0]  TS2ID   = 8'h45;

  os_scheduler dut_a (
    .clk(clk), .p2md_rstn(rst_a), .en_n(en_a), .currLtssmState(state_a),
    .ts1Bytes1Thru5(ts1_a), .ts2Bytes1Thru5(ts2_a),
    .rxdata(data_a), .rxdatak(k_a), .rxvalid(valid_a),
    .os_start(start_a), .os_done(done_a), .ts_count(cnt_a)
  );

  os_scheduler #(.SKP_INTERVAL(2)) dut_b (
    .clk(clk), .p2md_rstn(rst_b), .en_n(en_b), .currLtssmState(state_b),
    .ts1Bytes1Thru5(ts1_b), .ts2Bytes1Thru5(ts2_b),
    .rxdata(data_b), .rxdatak(k_b), .rxvalid(valid_b),
    .os_start(start_b), .os_done(done_b), .ts_count(cnt_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected {rxvalid, rxdatak, os_start, os_done, rxdata} for symbol i.
  function automatic logic [11:0] ts_sym(input logic [39:0] b, input logic [7:0] id, input int i);
    if (i == 0) return {4'b1110, 8'hBC};
    if (i <= 5) return {4'b1000, b[8*(i-1) +: 8]};
    return {3'b100, (i == 15), id};
  endfunction

  function automatic logic [11:0] skp_sym(input int i);
    if (i == 0) return {4'b1110, 8'hBC};
    return {3'b110, (i == 3), 8'h1C};
  endfunction

  task automatic do_event(input int ev);
    case (ev)
      1: en_a = 1'b1;
      2: ts1_a = TS1_ALT;
      3: state_b = POLLING_CONFIG;
      4: state_a = DETECT_QUIET;
      5: state_b = POLLING_ACTIVE;
      default: ;
    endcase
  endtask

  // Called at the falling edge showing COM; returns at the falling edge after
  // the last symbol checked.
  task automatic run_ts(input bit which, input logic [39:0] b, input logic [7:0] id,
                        input int nsym, input int ev_at, input int ev,
                        input logic [15:0] exp_cnt, input string tag);
    for (int i = 0; i < nsym; i++) begin
      check($sformatf("%s_s%0d", tag, i), which ? obs_b : obs_a, ts_sym(b, id, i));
      if (i == 0) check({tag, "_cnt"}, which ? cnt_b : cnt_a, exp_cnt);
      if (i == ev_at) do_event(ev);
      @(negedge clk);
    end
  endtask

  task automatic run_skp(input bit which, input logic [15:0] exp_cnt, input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_s%0d", tag, i), which ? obs_b : obs_a, skp_sym(i));
      if (i == 0) check({tag, "_cnt"}, which ? cnt_b : cnt_a, exp_cnt);
      @(negedge clk);
    end
  endtask

  initial begin
    int bad;
    rst_a = 1'b1; en_a = 1'b1; state_a = L0; ts1_a = TS1_A; ts2_a = 40'd0;
    rst_b = 1'b1; en_b = 1'b1; state_b = DETECT_QUIET; ts1_b = TS1_B; ts2_b = TS2_B;
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_out_a", obs_a, 12'h000);
    check("reset_cnt_a", cnt_a, 16'd0);
    check("reset_out_b", obs_b, 12'h000);

    // Instance A: L0 TS1 stream at the default interval of 8.
    rst_a = 1'b1;
    en_a  = 1'b0;
    @(negedge clk);
    run_ts(1'b0, TS1_A, TS1ID, 16, -1, 0, 16'd0, "a_set1");
    run_ts(1'b0, TS1_A, TS1ID, 16, -1, 0, 16'd1, "a_set2");
    run_ts(1'b0, TS1_A, TS1ID, 16, 3, 1, 16'd2, "a_set3");
    check("a_idle1", obs_a, 12'h000);
    check("a_idle_cnt", cnt_a, 16'd3);
    @(negedge clk);
    check("a_idle2", obs_a, 12'h000);
    en_a = 1'b0;
    @(negedge clk);
    run_ts(1'b0, TS1_A, TS1ID, 16, 2, 2, 16'd3, "a_set4");
    run_ts(1'b0, TS1_ALT, TS1ID, 16, -1, 0, 16'd4, "a_set5");
    run_ts(1'b0, TS1_ALT, TS1ID, 16, -1, 0, 16'd5, "a_set6");
    run_ts(1'b0, TS1_ALT, TS1ID, 16, -1, 0, 16'd6, "a_set7");
    run_ts(1'b0, TS1_ALT, TS1ID, 16, -1, 0, 16'd7, "a_set8");
    run_skp(1'b0, 16'd8, "a_skp1");
    run_ts(1'b0, TS1_ALT, TS1ID, 9, -1, 0, 16'd8, "a_set9");

    // Asynchronous reset while symbol 9 is on the wire.
    rst_a = 1'b0;
    #1;
    check("a_rst_mid_out", obs_a, 12'h000);
    check("a_rst_mid_cnt", cnt_a, 16'd0);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    run_ts(1'b0, TS1_ALT, TS1ID, 16, 4, 4, 16'd0, "a_set10");

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (valid_a !== 1'b0 || start_a !== 1'b0 || done_a !== 1'b0) bad++;
      @(negedge clk);
    end
    check("a_quiet_active_cycles", bad, 0);
    check("a_quiet_cnt", cnt_a, 16'd0);

    // Instance B: interval 2, TS1 -> TS2 switch mid-set, SKP insertion, SKP-only.
    state_b = POLLING_ACTIVE_START_TS1;
    en_b    = 1'b0;
    rst_b   = 1'b1;
    @(negedge clk);
    run_ts(1'b1, TS1_B, TS1ID, 16, -1, 0, 16'd0, "b_set1");
    run_ts(1'b1, TS1_B, TS1ID, 16, 7, 3, 16'd1, "b_set2");
    run_ts(1'b1, TS2_B, TS2ID, 16, -1, 0, 16'd0, "b_set3");
    run_ts(1'b1, TS2_B, TS2ID, 16, -1, 0, 16'd1, "b_set4");
    run_skp(1'b1, 16'd2, "b_skp1");
    run_ts(1'b1, TS2_B, TS2ID, 16, -1, 0, 16'd2, "b_set5");
    run_ts(1'b1, TS2_B, TS2ID, 16, -1, 0, 16'd3, "b_set6");
    run_skp(1'b1, 16'd4, "b_skp2");
    run_ts(1'b1, TS2_B, TS2ID, 16, 2, 5, 16'd4, "b_set7");
    run_skp(1'b1, 16'd0, "b_skponly1");
    run_skp(1'b1, 16'd0, "b_skponly2");
    run_skp(1'b1, 16'd0, "b_skponly3");
    check("b_skponly_cnt", cnt_b, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
